// File: rtl/icache_refill_axi.sv
// Instruction-cache line refill engine: one AXI4 INCR read burst per miss,
// beats gathered into a line buffer, full line returned as a single pulse.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a raised valid is never withdrawn before its transfer completes.
module icache_refill_axi #(
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rd_req,
  input  logic [31:0]               i_rd_addr,
  output logic                      o_rd_rdy,
  output logic                      o_ret_valid,
  output logic [32*LINE_WORDS-1:0]  o_ret_data,
  output logic                      o_refill_err,
  output logic [3:0]                o_arid,
  output logic [31:0]               o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  input  logic [3:0]                i_rid,
  input  logic [31:0]               i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast,
  input  logic                      i_rvalid,
  output logic                      o_rready,
  output logic [1:0]                o_dbg_state
);

  localparam int BW  = $clog2(LINE_WORDS);
  localparam int OFF = 2 + BW;
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFF) - 32'd1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AR    = 2'd1,
    S_RDATA = 2'd2,
    S_RET   = 2'd3
  } state_t;

  state_t                    r_state;
  logic [BW-1:0]             r_beat;
  logic [32*LINE_WORDS-1:0]  r_buf;
  logic                      w_last_beat;
  logic                      w_unused;

  // Burst shape is fixed at elaboration; rid and the line-offset address bits carry no information here.
  assign o_arid      = AXI_ID;
  assign o_arlen     = 8'(LINE_WORDS - 1);
  assign o_arsize    = 3'b010;
  assign o_arburst   = 2'b01;
  assign o_ret_data  = r_buf;
  assign o_dbg_state = r_state;
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_unused    = ^{i_rid, i_rd_addr[OFF-1:0]};

  // Refill sequencer: all handshake outputs are registered alongside the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_beat       <= '0;
      r_buf        <= '0;
      o_araddr     <= '0;
      o_rd_rdy     <= 1'b1;
      o_arvalid    <= 1'b0;
      o_rready     <= 1'b0;
      o_ret_valid  <= 1'b0;
      o_refill_err <= 1'b0;
    end else begin
      o_ret_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_rd_req) begin
            o_araddr  <= i_rd_addr & ADDR_MASK;
            r_beat    <= '0;
            o_rd_rdy  <= 1'b0;
            o_arvalid <= 1'b1;
            r_state   <= S_AR;
          end
        end
        S_AR: begin
          if (i_arready) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
            r_state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (i_rvalid) begin
            r_buf[r_beat*32 +: 32] <= i_rdata;
            r_beat <= r_beat + 1'b1;
            // Error responses are recorded but the data is kept; a misplaced
            // rlast is flagged while the beat count alone ends the burst.
            if (i_rresp != 2'b00 || i_rlast != w_last_beat) begin
              o_refill_err <= 1'b1;
            end
            if (w_last_beat) begin
              o_rready    <= 1'b0;
              o_ret_valid <= 1'b1;
              r_state     <= S_RET;
            end
          end
        end
        S_RET: begin
          o_rd_rdy <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_axi.sv
// Bench for icache_refill_axi: a driver issues refills and plays the AXI
// slave; expectations go into queues and a monitor checks returned lines,
// AR contents, return latency and the sticky error flag.
module tb_icache_refill_axi;

  localparam int LW = 4;

  logic            clk, rst;
  logic            rd_req;
  logic [31:0]     rd_addr;
  logic            rd_rdy, ret_valid, refill_err;
  logic [32*LW-1:0] ret_data;
  logic [3:0]      arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid, arready;
  logic [3:0]      rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready;
  logic [1:0]      dbg_state;

  icache_refill_axi #(.LINE_WORDS(LW), .AXI_ID(4'd0)) dut (
    .i_clk(clk), .i_rst(rst), .i_rd_req(rd_req), .i_rd_addr(rd_addr),
    .o_rd_rdy(rd_rdy), .o_ret_valid(ret_valid), .o_ret_data(ret_data),
    .o_refill_err(refill_err), .o_arid(arid), .o_araddr(araddr),
    .o_arlen(arlen), .o_arsize(arsize), .o_arburst(arburst),
    .o_arvalid(arvalid), .i_arready(arready), .i_rid(rid), .i_rdata(rdata),
    .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid), .o_rready(rready),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [32*LW-1:0] exp_q[$];
  int               exp_cyc_q[$];
  bit               exp_err_q[$];
  logic [31:0]      exp_ar_q[$];
  bit               err_model = 1'b0;
  int               last_ret_cyc = 0;
  int               n_cmp = 0;
  int               n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- monitor ----------------
  logic        prev_arvalid = 1'b0;
  logic        prev_hs = 1'b0;
  logic [31:0] prev_araddr = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_arvalid = 1'b0;
    end else begin
      if (ret_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_ret");
        end else begin
          chk("ret_data", 128'(ret_data), 128'(exp_q.pop_front()));
          chk("ret_latency", 128'(cyc + 1), 128'(exp_cyc_q.pop_front()));
          chk("refill_err", 128'(refill_err), 128'(exp_err_q.pop_front()));
        end
      end
      if (prev_arvalid && !prev_hs) begin
        chk("arvalid_held", 128'(arvalid), 128'(1'b1));
        chk("araddr_stable", 128'(araddr), 128'(prev_araddr));
      end
      if (arvalid && arready) begin
        if (exp_ar_q.size() == 0) begin
          fail_now("unexpected_ar");
        end else begin
          chk("araddr", 128'(araddr), 128'(exp_ar_q.pop_front()));
          chk("arlen", 128'(arlen), 128'(LW - 1));
          chk("arsize", 128'(arsize), 128'(3'b010));
          chk("arburst", 128'(arburst), 128'(2'b01));
          chk("arid", 128'(arid), 128'(4'd0));
        end
      end
      prev_arvalid = arvalid;
      prev_hs      = arvalid && arready;
      prev_araddr  = araddr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    err_model = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || exp_ar_q.size() != 0) && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0 || exp_ar_q.size() != 0) begin
      fail_now("drain");
      exp_q.delete(); exp_cyc_q.delete(); exp_err_q.delete(); exp_ar_q.delete();
    end
  endtask

  // One refill: request, AR acceptance after d stall cycles, beats with
  // g[i] idle cycles before beat i, optional misplaced rlast / bad rresp.
  task automatic do_refill(input logic [31:0] addr, input logic [31:0] w[LW],
                           input int d, input int g[LW], input int bad_last,
                           input int bad_resp, input bit hold_req, input bit chk_hold);
    int t;
    int guard;
    int gsum;
    logic [32*LW-1:0] line;
    guard = 0;
    @(negedge clk);
    while (!rd_rdy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!rd_rdy) begin
      fail_now("accept_wait");
      return;
    end
    rd_req  = 1'b1;
    rd_addr = addr;
    @(posedge clk);
    #1;
    t = cyc;
    if (chk_hold) chk("hold_reaccept_cycle", 128'(t), 128'(last_ret_cyc + 1));
    if (!hold_req) rd_req = 1'b0;

    // Reference: line = words in beat order, address rounded down to the line.
    line = '0;
    gsum = 0;
    for (int i = 0; i < LW; i++) begin
      line[i*32 +: 32] = w[i];
      gsum += g[i];
    end
    if (bad_last >= 0 || bad_resp >= 0) err_model = 1'b1;
    exp_q.push_back(line);
    exp_err_q.push_back(err_model);
    exp_ar_q.push_back((addr / (LW * 4)) * (LW * 4));
    last_ret_cyc = t + 2 + d + LW + gsum;
    exp_cyc_q.push_back(last_ret_cyc);

    arready = (d == 0);
    if (d > 0) begin
      repeat (d) begin @(posedge clk); #1; end
      arready = 1'b1;
    end
    @(posedge clk);
    #1;
    arready = 1'b0;

    for (int i = 0; i < LW; i++) begin
      rvalid = 1'b0;
      repeat (g[i]) begin @(posedge clk); #1; end
      rvalid = 1'b1;
      rdata  = w[i];
      rlast  = (i == LW - 1) ^ (i == bad_last);
      rresp  = (i == bad_resp) ? 2'($urandom_range(1, 3)) : 2'b00;
      rid    = 4'($urandom_range(0, 15));
      guard  = 0;
      @(negedge clk);
      while (!rready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!rready) begin
        fail_now("rready_wait");
        break;
      end
      @(posedge clk);
      #1;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] w[LW];
  int          g[LW];
  int          gz[LW];

  initial begin
    rst = 1'b1; rd_req = 1'b0; rd_addr = '0; arready = 1'b0;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    for (int i = 0; i < LW; i++) gz[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_rdy", 128'(rd_rdy), 128'(1'b1));
    chk("rst_arvalid", 128'(arvalid), 128'(1'b0));
    chk("rst_ret_valid", 128'(ret_valid), 128'(1'b0));
    chk("rst_rready", 128'(rready), 128'(1'b0));
    chk("rst_refill_err", 128'(refill_err), 128'(1'b0));
    chk("rst_ret_data", 128'(ret_data), 128'(0));
    chk("rst_araddr", 128'(araddr), 128'(0));
    rst = 1'b0;

    // Unaligned address, no stalls: line at 0x1FC00A10, return at T+6.
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
    do_refill(32'h1FC0_0A1C, w, 0, gz, -1, -1, 1'b0, 1'b0);
    drain();

    // AR stalled five cycles.
    for (int i = 0; i < LW; i++) w[i] = $urandom;
    do_refill(32'h0000_1234, w, 5, gz, -1, -1, 1'b0, 1'b0);
    drain();

    // Beats at relative cycles 0,3,4,9.
    g[0] = 0; g[1] = 2; g[2] = 0; g[3] = 4;
    for (int i = 0; i < LW; i++) w[i] = $urandom;
    do_refill(32'hDEAD_BEEF, w, 1, g, -1, -1, 1'b0, 1'b0);
    drain();

    // rd_req held through RET: next request taken the cycle after IDLE returns.
    for (int i = 0; i < LW; i++) w[i] = $urandom;
    do_refill(32'h8000_0040, w, 0, gz, -1, -1, 1'b1, 1'b0);
    for (int i = 0; i < LW; i++) w[i] = $urandom;
    do_refill(32'h8000_0040, w, 0, gz, -1, -1, 1'b0, 1'b1);
    drain();

    // Early rlast, then an error response: flag set and sticky.
    for (int i = 0; i < LW; i++) w[i] = $urandom;
    do_refill(32'h0000_0100, w, 0, gz, 1, -1, 1'b0, 1'b0);
    for (int i = 0; i < LW; i++) w[i] = $urandom;
    do_refill(32'h0000_0200, w, 2, gz, -1, 2, 1'b0, 1'b0);
    drain();

    // Asynchronous reset while AR is pending.
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 32'h4444_4444;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    @(posedge clk);
    #1;
    chk("midar_arvalid_before", 128'(arvalid), 128'(1'b1));
    rst = 1'b1;
    #1;
    chk("midar_arvalid", 128'(arvalid), 128'(1'b0));
    chk("midar_rd_rdy", 128'(rd_rdy), 128'(1'b1));
    chk("midar_ret_data", 128'(ret_data), 128'(0));
    chk("midar_refill_err", 128'(refill_err), 128'(1'b0));
    chk("midar_araddr", 128'(araddr), 128'(0));
    err_model = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Error response alone raises the flag.
    for (int i = 0; i < LW; i++) w[i] = $urandom;
    do_refill(32'h0000_0300, w, 0, gz, -1, 0, 1'b0, 1'b0);
    drain();

    // Randomized refills; rlast on final beat dropped in some of them.
    do_reset();
    for (int n = 0; n < 30; n++) begin
      int bl;
      int br;
      for (int i = 0; i < LW; i++) begin
        w[i] = $urandom;
        g[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      bl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
      br = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
      do_refill($urandom, w, int'($urandom_range(0, 4)), g, bl, br, 1'b0, 1'b0);
    end
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    fail_now("global_timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
